// File: rtl/scan_pkg.sv
// Shared constants and types for the seven-segment scan controller and its decoder stage.
package scan_pkg;

  localparam int DIGITS = 4;
  localparam int IDX_W  = 2;
  localparam int VAL_W  = 4;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [VAL_W-1:0] val_t;

endpackage

// File: rtl/scan_ctrl_tick_gen.sv
// Refresh divider: counts 0..DIV_MAX while run is high and flags the terminal count.
module tick_gen #(
  parameter int DIV_W   = 16,
  parameter int DIV_MAX = 49999
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tc
);

  logic [DIV_W-1:0] cnt;

  if (DIV_MAX < 0 || longint'(DIV_MAX) > ((longint'(1) << DIV_W) - 1)) begin : g_div_max_range
    $error("tick_gen: DIV_MAX does not fit in DIV_W bits");
  end

  // tc is qualified by run so a frozen divider never reports a terminal count.
  assign tc = run && (cnt == DIV_W'(DIV_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (run) begin
      // NOTE: clocked state always uses <= so every register samples pre-edge values.
      cnt <= tc ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// Four-digit display scan controller with a shadow value committed at frame boundaries.
// Optional blink of the whole display is enabled by defining SCAN_BLINK_EN.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int DIV_MAX      = 49999,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [VAL_W-1:0] din,
  input  logic             frz,
  output idx_t             en,
  output logic [VAL_W-1:0] num,
  output logic             tick,
  output logic             pending,
  output logic             blank
);

  logic       tc;
  logic       wrap;
  val_t       shadow;

  if (BLINK_FRAMES < 1) begin : g_blink_range
    $error("scan_ctrl: BLINK_FRAMES must be at least 1");
  end

  tick_gen #(
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .run (~frz),
    .tc  (tc)
  );

  // A frame ends when the last digit hands over to digit 0.
  assign wrap = tc && (en == idx_t'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register here is plain state, so all of it is reset explicitly.
      en      <= '0;
      num     <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= tc;
      if (tc) en <= en + idx_t'(1);
      if (load) shadow <= din;
      // On a coincident load the old shadow commits and the new one stays pending.
      if (wrap && pending) begin
        num     <= shadow;
        pending <= load;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef SCAN_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FR_W-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      blank     <= 1'b0;
    end else if (wrap) begin
      if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blank     <= ~blank;
      end else begin
        frame_cnt <= frame_cnt + FR_W'(1);
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl with DIV_MAX=3 (plus a DIV_MAX=0 instance for the boundary case).
module tb_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] din;
  logic       frz;

  logic [1:0] en,  en0;
  logic [3:0] num, num0;
  logic       tick, tick0, pending, pending0, blank, blank0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_ctrl #(.DIV_W(16), .DIV_MAX(3), .BLINK_FRAMES(2)) u_dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .frz(frz),
    .en(en), .num(num), .tick(tick), .pending(pending), .blank(blank)
  );

  scan_ctrl #(.DIV_W(4), .DIV_MAX(0), .BLINK_FRAMES(2)) u_dut0 (
    .clk(clk), .rst(rst), .load(load), .din(din), .frz(frz),
    .en(en0), .num(num0), .tick(tick0), .pending(pending0), .blank(blank0)
  );

  typedef struct {
    logic       load;
    logic [3:0] din;
    logic [1:0] en;
    logic [3:0] num;
    logic       tick;
    logic       pending;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic vec_t mk(input logic l, input logic [3:0] d, input logic [1:0] e,
                              input logic [3:0] n, input logic t, input logic p);
    vec_t v;
    v.load = l; v.din = d; v.en = e; v.num = n; v.tick = t; v.pending = p;
    return v;
  endfunction

  initial begin
    // Rotation and deferred commit from a fresh reset; each row is one clock.
    vecs[0]  = mk(0, 4'h0, 2'd0, 4'h0, 0, 0);
    vecs[1]  = mk(0, 4'h0, 2'd0, 4'h0, 0, 0);
    vecs[2]  = mk(0, 4'h0, 2'd0, 4'h0, 0, 0);
    vecs[3]  = mk(0, 4'h0, 2'd1, 4'h0, 1, 0);
    vecs[4]  = mk(1, 4'hA, 2'd1, 4'h0, 0, 1);
    vecs[5]  = mk(0, 4'h0, 2'd1, 4'h0, 0, 1);
    vecs[6]  = mk(0, 4'h0, 2'd1, 4'h0, 0, 1);
    vecs[7]  = mk(0, 4'h0, 2'd2, 4'h0, 1, 1);
    vecs[8]  = mk(0, 4'h0, 2'd2, 4'h0, 0, 1);
    vecs[9]  = mk(0, 4'h0, 2'd2, 4'h0, 0, 1);
    vecs[10] = mk(0, 4'h0, 2'd2, 4'h0, 0, 1);
    vecs[11] = mk(0, 4'h0, 2'd3, 4'h0, 1, 1);
    vecs[12] = mk(0, 4'h0, 2'd3, 4'h0, 0, 1);
    vecs[13] = mk(0, 4'h0, 2'd3, 4'h0, 0, 1);
    vecs[14] = mk(0, 4'h0, 2'd3, 4'h0, 0, 1);
    vecs[15] = mk(0, 4'h0, 2'd0, 4'hA, 1, 0);
    vecs[16] = mk(0, 4'h0, 2'd0, 4'hA, 0, 0);
    vecs[17] = mk(0, 4'h0, 2'd0, 4'hA, 0, 0);
    vecs[18] = mk(0, 4'h0, 2'd0, 4'hA, 0, 0);
    vecs[19] = mk(0, 4'h0, 2'd1, 4'hA, 1, 0);

    rst = 1'b1; load = 1'b0; din = 4'h0; frz = 1'b0;
    step_n(2);
    rst = 1'b0;
    check("reset_en", en, 0);
    check("reset_num", num, 0);
    check("reset_tick", tick, 0);
    check("reset_pending", pending, 0);
    check("reset_blank", blank, 0);

    for (int i = 0; i < 20; i++) begin
      load = vecs[i].load;
      din  = vecs[i].din;
      step();
      check($sformatf("vec%0d_en", i), en, vecs[i].en);
      check($sformatf("vec%0d_num", i), num, vecs[i].num);
      check($sformatf("vec%0d_tick", i), tick, vecs[i].tick);
      check($sformatf("vec%0d_pending", i), pending, vecs[i].pending);
    end
    load = 1'b0;

    // Load at the commit edge: en=1, divider at 0 here.
    load = 1'b1; din = 4'b0011;
    step();
    load = 1'b0;
    check("lc_pending", pending, 1);
    step_n(10);
    check("lc_pre_en", en, 3);
    check("lc_pre_num", num, 4'hA);
    load = 1'b1; din = 4'b1100;
    step();
    load = 1'b0;
    check("lc_wrap_en", en, 0);
    check("lc_wrap_tick", tick, 1);
    check("lc_wrap_num", num, 4'b0011);
    check("lc_wrap_pending", pending, 1);
    step_n(15);
    check("lc_pre2_en", en, 3);
    check("lc_pre2_num", num, 4'b0011);
    step();
    check("lc_wrap2_en", en, 0);
    check("lc_wrap2_num", num, 4'b1100);
    check("lc_wrap2_pending", pending, 0);

    // Freeze at en=2 for 20 clocks, loading during the freeze.
    step_n(8);
    check("frz_start_en", en, 2);
    frz = 1'b1;
    for (int i = 0; i < 20; i++) begin
      load = (i == 5);
      din  = 4'b1111;
      step();
      check($sformatf("frz%0d_en", i), en, 2);
      check($sformatf("frz%0d_tick", i), tick, 0);
    end
    load = 1'b0;
    check("frz_num", num, 4'b1100);
    check("frz_pending", pending, 1);
    frz = 1'b0;
    step_n(3);
    check("frz_resume_hold_en", en, 2);
    step();
    check("frz_resume_en", en, 3);
    check("frz_resume_tick", tick, 1);
    step_n(3);
    check("frz_pre_commit_num", num, 4'b1100);
    step();
    check("frz_commit_en", en, 0);
    check("frz_commit_num", num, 4'b1111);
    check("frz_commit_pending", pending, 0);

    // Reset mid-scan (with a load present, which reset must override).
    step_n(10);
    check("rst_mid_pre_en", en, 2);
    rst = 1'b1; load = 1'b1; din = 4'b0101;
    step();
    rst = 1'b0; load = 1'b0;
    check("rst_mid_en", en, 0);
    check("rst_mid_num", num, 0);
    check("rst_mid_pending", pending, 0);
    check("rst_mid_tick", tick, 0);
    step_n(3);
    check("rst_mid_hold_en", en, 0);
    step();
    check("rst_mid_adv_en", en, 1);
    check("rst_mid_adv_tick", tick, 1);

    // Blink over six frames from reset; DIV_MAX=0 instance checked alongside.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("blink_reset", blank, 0);
    for (int s = 1; s <= 96; s++) begin
      logic exp_blank;
      step();
`ifdef SCAN_BLINK_EN
      exp_blank = ((s / 16) / 2) % 2 == 1;
`else
      exp_blank = 1'b0;
`endif
      check($sformatf("blank_s%0d", s), blank, exp_blank);
      if (s <= 8) begin
        check($sformatf("d0_en_s%0d", s), en0, s % 4);
        check($sformatf("d0_tick_s%0d", s), tick0, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
